// File: rtl/boot_memory_pkg.sv
// Shared definitions for the boot-loading main memory: data width and FSM state encodings.
package boot_memory_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        BOOT_LOAD    = 2'd0,
        BOOT_RELEASE = 2'd1,
        BOOT_RUN     = 2'd2
    } boot_state_e;

endpackage

// File: rtl/ram_256x8.sv
// Single-port-write RAM with synchronous write and asynchronous read; contents have no reset.
module ram_256x8
    import boot_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tristate_buffer.sv
// Generic tristate driver: passes d to y when en is high, otherwise releases the net.
module tristate_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output wire  [WIDTH-1:0] y
);

    assign y = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/boot_memory.sv
// CPU main memory with a sequential boot loader that holds the CPU in reset until the
// program image has been streamed in, then serves CPU reads/writes over the shared bus.
module boot_memory
    import boot_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RELEASE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_bus,
    input  logic                  c_ri,
    input  logic                  c_ro,
    input  logic                  mem_en,
    inout  wire  [DATA_WIDTH-1:0] bus,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  reload,
    output logic                  cpu_reset,
    output logic                  loaded,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    boot_state_e           state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [RelW-1:0]       rel_q;

    logic                  accept;
    logic                  cpu_we;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  bus_oe;

    assign accept = (state_q == BOOT_LOAD) && load_valid;
    // reload wins over a CPU write landing on the same edge
    assign cpu_we = (state_q == BOOT_RUN) && !reload && mem_en && c_ri;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT_LOAD;
            ptr_q   <= '0;
            count_q <= '0;
            rel_q   <= '0;
        end else begin
            case (state_q)
                BOOT_LOAD: begin
                    if (accept) begin
                        ptr_q   <= ptr_q + ADDR_WIDTH'(1);
                        count_q <= count_q + (ADDR_WIDTH + 1)'(1);
                        // A full image ends loading even without an explicit last marker
                        if (load_last || (ptr_q == '1)) begin
                            state_q <= BOOT_RELEASE;
                            rel_q   <= RelW'(RELEASE_CYCLES - 1);
                        end
                    end
                end
                BOOT_RELEASE: begin
                    if (reload) begin
                        state_q <= BOOT_LOAD;
                        ptr_q   <= '0;
                        count_q <= '0;
                    end else if (rel_q == '0) begin
                        state_q <= BOOT_RUN;
                    end else begin
                        rel_q <= rel_q - RelW'(1);
                    end
                end
                BOOT_RUN: begin
                    if (reload) begin
                        state_q <= BOOT_LOAD;
                        ptr_q   <= '0;
                        count_q <= '0;
                    end
                end
                default: state_q <= BOOT_LOAD;
            endcase
        end
    end

    assign load_ready = (state_q == BOOT_LOAD);
    assign cpu_reset  = (state_q != BOOT_RUN);
    assign loaded     = (state_q == BOOT_RUN);
    assign load_count = count_q;

    assign ram_we    = accept || cpu_we;
    assign ram_waddr = (state_q == BOOT_LOAD) ? ptr_q : addr_bus;
    assign ram_wdata = (state_q == BOOT_LOAD) ? load_data : bus;

    ram_256x8 #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(addr_bus),
        .rdata(ram_rdata)
    );

    // Never drive while the CPU is also writing, so the bus has a single driver
    assign bus_oe = (state_q == BOOT_RUN) && c_ro && !c_ri;

    tristate_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_bus_drv (
        .en(bus_oe),
        .d (ram_rdata),
        .y (bus)
    );

endmodule
